// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS-I subset core: opcodes, ALU
// select encoding, FSM states and the ALU function itself.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_sel_t;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALT
  } state_t;

  function automatic alu_sel_t funct_to_alu(logic [5:0] funct);
    alu_sel_t sel;
    sel = ALU_ADD;
    case (funct)
      FN_SUB:  sel = ALU_SUB;
      FN_AND:  sel = ALU_AND;
      FN_OR:   sel = ALU_OR;
      FN_SLT:  sel = ALU_SLT;
      default: sel = ALU_ADD;
    endcase
    return sel;
  endfunction

  // Two's complement throughout; add/sub wrap silently and slt is signed.
  function automatic logic [31:0] alu_op(alu_sel_t sel, logic [31:0] a, logic [31:0] b);
    logic [31:0] res;
    res = a + b;
    case (sel)
      ALU_SUB: res = a - b;
      ALU_AND: res = a & b;
      ALU_OR:  res = a | b;
      ALU_SLT: res = {31'b0, ($signed(a) < $signed(b))};
      default: res = a + b;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write
// port, r0 hardwired to zero, all registers cleared on reset.
module mips_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  logic [31:0] regs [1:31];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (wa != 5'd0)) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? 32'h0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'h0 : regs[ra2];

endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-I subset core sharing one instruction/data memory port
// with a req/ready handshake; reports retire, halt and illegal status.
module mips_multicycle_core
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W          = 32,
  parameter logic [31:0] RESET_PC        = 32'h0,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic              instr_retired,
  output logic              illegal,
  output logic              halted,
  output logic [ADDR_W-1:0] pc_out
);

  localparam logic [ADDR_W-1:0] RESET_ADDR = RESET_PC[ADDR_W-1:0];

  state_t            state, state_nx;
  logic [ADDR_W-1:0] pc, bt, jump_target;
  logic [31:0]       ir, a_q, b_q, alu_out, mdr;
  logic              illegal_q;

  logic [5:0]        op, funct;
  logic [4:0]        rs, rt, rd;
  logic [31:0]       imm_sext, br_off;
  logic              is_r, is_lw, is_sw, is_beq, is_addi, is_j;
  logic              funct_ok, instr_ok;

  alu_sel_t          alu_sel;
  logic [31:0]       alu_b, alu_res;
  logic              misaligned;

  logic              req_c, we_c, retire_c, set_illegal, take_jump;
  logic [31:0]       rf_rd1, rf_rd2, rf_wd;
  logic [4:0]        rf_wa;
  logic              rf_we;

  assign op       = ir[31:26];
  assign funct    = ir[5:0];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign imm_sext = {{16{ir[15]}}, ir[15:0]};
  assign br_off   = {imm_sext[29:0], 2'b00};

  // Instruction classification; anything not listed here is illegal.
  always_comb begin
    is_r     = (op == OP_RTYPE);
    is_lw    = (op == OP_LW);
    is_sw    = (op == OP_SW);
    is_beq   = (op == OP_BEQ);
    is_addi  = (op == OP_ADDI);
    is_j     = (op == OP_J);
    funct_ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
               (funct == FN_OR)  || (funct == FN_SLT);
    instr_ok = (is_r && funct_ok) || is_lw || is_sw || is_beq || is_addi || is_j;
  end

  assign alu_sel    = is_r ? funct_to_alu(funct) : ALU_ADD;
  assign alu_b      = is_r ? b_q : imm_sext;
  assign alu_res    = alu_op(alu_sel, a_q, alu_b);
  assign misaligned = (is_lw || is_sw) && (alu_res[1:0] != 2'b00);

  // The region above bit 27 of the jump target comes from PC+4 only when the
  // address space is wide enough to have one.
  generate
    if (ADDR_W > 28) begin : g_jt_wide
      assign jump_target = {pc[ADDR_W-1:28], ir[25:0], 2'b00};
    end else begin : g_jt_narrow
      logic [27:0] jt_full;
      assign jt_full     = {ir[25:0], 2'b00};
      assign jump_target = jt_full[ADDR_W-1:0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    req_c       = 1'b0;
    we_c        = 1'b0;
    retire_c    = 1'b0;
    set_illegal = 1'b0;
    take_jump   = 1'b0;
    case (state)
      FETCH: begin
        req_c = 1'b1;
        if (mem_ready) state_nx = DECODE;
      end
      DECODE: begin
        if (!instr_ok) begin
          set_illegal = 1'b1;
          retire_c    = !HALT_ON_ILLEGAL;
          state_nx    = HALT_ON_ILLEGAL ? HALT : FETCH;
        end else if (is_j) begin
          take_jump = 1'b1;
          retire_c  = 1'b1;
          state_nx  = FETCH;
        end else begin
          state_nx = EXEC;
        end
      end
      EXEC: begin
        if (misaligned) begin
          set_illegal = 1'b1;
          retire_c    = !HALT_ON_ILLEGAL;
          state_nx    = HALT_ON_ILLEGAL ? HALT : FETCH;
        end else if (is_lw || is_sw) begin
          state_nx = MEM;
        end else if (is_beq) begin
          retire_c = 1'b1;
          state_nx = FETCH;
        end else begin
          state_nx = WB;
        end
      end
      MEM: begin
        req_c = 1'b1;
        we_c  = is_sw;
        if (mem_ready) begin
          retire_c = is_sw;
          state_nx = is_sw ? FETCH : WB;
        end
      end
      WB: begin
        retire_c = 1'b1;
        state_nx = FETCH;
      end
      HALT:    state_nx = HALT;
      default: state_nx = FETCH;
    endcase
  end

  // Architectural datapath registers; each only moves in the state that owns
  // it, so address/data presented to memory stay put across wait states.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_ADDR;
      ir        <= '0;
      a_q       <= '0;
      b_q       <= '0;
      bt        <= '0;
      alu_out   <= '0;
      mdr       <= '0;
      illegal_q <= 1'b0;
    end else begin
      if (set_illegal) illegal_q <= 1'b1;
      case (state)
        FETCH: begin
          if (mem_ready) begin
            ir <= mem_rdata;
            pc <= pc + ADDR_W'(4);
          end
        end
        DECODE: begin
          a_q <= rf_rd1;
          b_q <= rf_rd2;
          bt  <= pc + br_off[ADDR_W-1:0];
          if (take_jump) pc <= jump_target;
        end
        EXEC: begin
          alu_out <= alu_res;
          if (is_beq && (a_q == b_q)) pc <= bt;
        end
        MEM: begin
          if (mem_ready && is_lw) mdr <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

  assign rf_we = (state == WB) && !rst;
  assign rf_wa = is_r ? rd : rt;
  assign rf_wd = is_lw ? mdr : alu_out;

  mips_regfile u_regfile (
    .clk (clk),
    .rst (rst),
    .ra1 (rs),
    .ra2 (rt),
    .rd1 (rf_rd1),
    .rd2 (rf_rd2),
    .we  (rf_we),
    .wa  (rf_wa),
    .wd  (rf_wd)
  );

  assign mem_req       = req_c && !rst;
  assign mem_we        = we_c;
  assign mem_addr      = (state == MEM) ? alu_out[ADDR_W-1:0] : pc;
  assign mem_wdata     = b_q;
  assign instr_retired = retire_c && !rst;
  assign illegal       = illegal_q;
  assign halted        = (state == HALT) && !rst;
  assign pc_out        = pc;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Self-checking bench for mips_multicycle_core: directed programs plus random
// programs, compared against an instruction-level ISA model.
module tb_mips_multicycle_core;

  localparam int          ADDR_W     = 32;
  localparam logic [31:0] RESET_PC   = 32'h0;
  localparam int          DUMP_IDX   = 'hC0;
  localparam int          SAVE_IDX   = 'h180;
  localparam int          DATA_IDX   = 'h100;
  localparam int          MAX_CYCLES = 4000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              mem_req, mem_we, mem_ready;
  logic [ADDR_W-1:0] mem_addr, pc_out;
  logic [31:0]       mem_wdata, mem_rdata;
  logic              instr_retired, illegal, halted;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mips_multicycle_core #(
    .ADDR_W          (ADDR_W),
    .RESET_PC        (RESET_PC),
    .HALT_ON_ILLEGAL (1'b1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata),
    .instr_retired (instr_retired),
    .illegal       (illegal),
    .halted        (halted),
    .pc_out        (pc_out)
  );

  // Word memory with a configurable number of wait states per transfer.
  logic [31:0] mem [0:1023];
  logic        tbWe = 1'b0;
  logic [9:0]  tbIdx = '0;
  logic [31:0] tbData = '0;
  logic [3:0]  waitCfg = '0;
  logic [3:0]  waitCnt = '0;

  always @(posedge clk) begin
    if (tbWe) mem[tbIdx] <= tbData;
    else if (mem_req && mem_we && mem_ready) mem[mem_addr[11:2]] <= mem_wdata;
    if (rst || !mem_req || mem_ready) waitCnt <= '0;
    else waitCnt <= waitCnt + 4'd1;
  end

  assign mem_ready = mem_req && (waitCnt >= waitCfg);
  assign mem_rdata = mem[mem_addr[11:2]];

  // ISA-level reference model.
  logic [31:0] mregs [0:31];
  logic [31:0] mmem  [0:1023];
  logic [31:0] mpc;
  int          mWait;

  logic [31:0] prog [$];
  int          dIdx [$];
  logic [31:0] dVal [$];

  function automatic logic [31:0] rtype(int rs, int rt, int rd, logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(logic [5:0] op, int rs, int rt, logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] jtype(int target);
    return {6'h02, 26'(target)};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    mpc = RESET_PC;
  endtask

  task automatic modelStep(output bit halts, output int gap);
    logic [31:0] ins, a, b, simm, addr, res;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd;
    bit          ok;
    ins  = mmem[mpc[11:2]];
    op   = ins[31:26];
    fn   = ins[5:0];
    rs   = ins[25:21];
    rt   = ins[20:16];
    rd   = ins[15:11];
    a    = mregs[rs];
    b    = mregs[rt];
    simm = {{16{ins[15]}}, ins[15:0]};
    res  = '0;
    halts = 1'b0;
    mpc  = mpc + 32'd4;
    case (op)
      6'h00: begin
        ok = 1'b1;
        case (fn)
          6'h20: res = a + b;
          6'h22: res = a - b;
          6'h24: res = a & b;
          6'h25: res = a | b;
          6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: ok = 1'b0;
        endcase
        if (ok) begin
          if (rd != 0) mregs[rd] = res;
          gap = 4 + mWait;
        end else begin
          halts = 1'b1;
          gap   = 3 + mWait;
        end
      end
      6'h08: begin
        if (rt != 0) mregs[rt] = a + simm;
        gap = 4 + mWait;
      end
      6'h23, 6'h2B: begin
        addr = a + simm;
        if (addr[1:0] != 2'b00) begin
          halts = 1'b1;
          gap   = 4 + mWait;
        end else if (op == 6'h23) begin
          if (rt != 0) mregs[rt] = mmem[addr[11:2]];
          gap = 5 + 2 * mWait;
        end else begin
          mmem[addr[11:2]] = b;
          gap = 4 + 2 * mWait;
        end
      end
      6'h04: begin
        if (a == b) mpc = mpc + (simm << 2);
        gap = 3 + mWait;
      end
      6'h02: begin
        mpc = {mpc[31:28], ins[25:0], 2'b00};
        gap = 2 + mWait;
      end
      default: begin
        halts = 1'b1;
        gap   = 3 + mWait;
      end
    endcase
  endtask

  // Loads body + jump to the register-dump routine + data words, holding reset.
  task automatic applyStimulus(input int waits);
    logic [31:0] img [0:1023];
    @(negedge clk);
    rst     = 1'b1;
    waitCfg = 4'(waits);
    mWait   = waits;
    for (int i = 0; i < 1024; i++) img[i] = '0;
    foreach (prog[i]) img[i] = prog[i];
    img[prog.size()] = jtype(DUMP_IDX);
    for (int r = 1; r < 32; r++) img[DUMP_IDX + r - 1] = itype(6'h2B, 0, r, 16'((SAVE_IDX + r) * 4));
    img[DUMP_IDX + 31] = 32'hFC00_0000;
    foreach (dIdx[i]) img[dIdx[i]] = dVal[i];
    tbWe = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      tbIdx  = 10'(i);
      tbData = img[i];
      mmem[i] = img[i];
      @(negedge clk);
    end
    tbWe = 1'b0;
    modelReset();
    checkOutput("reset_state", {pc_out, mem_req, instr_retired, halted, illegal},
                {RESET_PC, 4'b0000});
  endtask

  task automatic runProgram(input int maxRetires);
    int  cyc, lastEvt, retires, gap;
    bit  hlt, done;
    cyc = 1; lastEvt = 0; retires = 0; done = 1'b0;
    rst = 1'b0;
    #1;
    checkOutput("first_fetch", {mem_req, mem_addr}, {1'b1, RESET_PC});
    while (!done) begin
      if (cyc > MAX_CYCLES) begin
        checkOutput("cycle_budget", 64'(cyc), 64'(MAX_CYCLES));
        done = 1'b1;
      end else if (instr_retired) begin
        modelStep(hlt, gap);
        checkOutput("retire_not_halt", 64'(hlt), 64'd0);
        checkOutput("retire_gap", 64'(cyc - lastEvt), 64'(gap));
        checkOutput("illegal_clear", 64'(illegal), 64'd0);
        lastEvt = cyc;
        retires++;
        @(negedge clk);
        cyc++;
        checkOutput("pc_after_retire", 64'(pc_out), 64'(mpc));
        if (maxRetires != 0 && retires >= maxRetires) done = 1'b1;
      end else if (halted) begin
        modelStep(hlt, gap);
        checkOutput("halt_expected", 64'(hlt), 64'd1);
        checkOutput("halt_gap", 64'(cyc - lastEvt), 64'(gap));
        checkOutput("halt_illegal_req", {illegal, mem_req}, 2'b10);
        repeat (4) @(negedge clk);
        checkOutput("halt_sticky", {halted, illegal, mem_req, instr_retired}, 4'b1100);
        done = 1'b1;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
  endtask

  task automatic checkDump();
    for (int r = 1; r < 32; r++) checkOutput("dump_reg", mem[SAVE_IDX + r], mmem[SAVE_IDX + r]);
  endtask

  task automatic clearProgram();
    prog.delete();
    dIdx.delete();
    dVal.delete();
  endtask

  initial begin
    logic [5:0] fnList [5];
    bit         found;
    int         n, k, off;
    fnList = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

    // addi/addi/add: r3 = 5 + (-3)
    clearProgram();
    prog = '{itype(6'h08, 0, 1, 16'd5), itype(6'h08, 0, 2, 16'hFFFD), rtype(1, 2, 3, 6'h20)};
    applyStimulus(0);
    runProgram(0);
    checkOutput("t1_r3", mem[SAVE_IDX + 3], 32'd2);
    checkDump();

    // store then load through 2-wait-state memory
    clearProgram();
    prog = '{itype(6'h08, 0, 1, 16'h40), itype(6'h2B, 1, 1, 16'h0), itype(6'h23, 1, 4, 16'h0)};
    applyStimulus(2);
    runProgram(0);
    checkOutput("t2_mem40", mem['h10], 32'h40);
    checkOutput("t2_r4", mem[SAVE_IDX + 4], 32'h40);
    checkDump();

    // tight taken-branch loop at 0x10
    clearProgram();
    for (int i = 0; i < 4; i++) prog.push_back(itype(6'h08, 0, 0, 16'h0));
    prog.push_back(itype(6'h04, 0, 0, 16'hFFFF));
    applyStimulus(0);
    runProgram(10);
    checkOutput("t3_loop_pc", 64'(pc_out), 64'h10);

    // jump to 0x400, which holds an illegal opcode
    clearProgram();
    prog = '{jtype('h100)};
    dIdx.push_back('h100); dVal.push_back(32'hFC00_0000);
    applyStimulus(0);
    runProgram(0);

    // illegal opcode right after a good instruction, then misaligned lw and sw
    clearProgram();
    prog = '{itype(6'h08, 0, 1, 16'd9), 32'hFC00_0000};
    applyStimulus(1);
    runProgram(0);
    clearProgram();
    prog = '{itype(6'h08, 0, 1, 16'd1), itype(6'h23, 1, 2, 16'h0)};
    applyStimulus(0);
    runProgram(0);
    clearProgram();
    prog = '{itype(6'h08, 0, 1, 16'd2), itype(6'h2B, 1, 1, 16'h0)};
    applyStimulus(0);
    runProgram(0);

    // reset in the middle of a lw memory wait
    clearProgram();
    prog = '{itype(6'h08, 0, 1, 16'h40), itype(6'h23, 1, 4, 16'h0)};
    dIdx.push_back('h10); dVal.push_back(32'hCAFE_0004);
    applyStimulus(2);
    rst = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge clk);
      if (mem_req && !mem_we && mem_addr == 32'h40) found = 1'b1;
    end
    checkOutput("t6_lw_wait_seen", 64'(found), 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("t6_req_in_reset", 64'(mem_req), 64'd0);
    @(negedge clk);
    checkOutput("t6_after_reset", {pc_out, mem_req, halted, instr_retired}, {RESET_PC, 3'b000});
    modelReset();
    runProgram(0);
    checkOutput("t6_r4", mem[SAVE_IDX + 4], 32'hCAFE_0004);
    checkDump();

    // random programs with forward-only control flow
    for (int p = 0; p < 6; p++) begin
      clearProgram();
      n = $urandom_range(10, 40);
      for (int i = 0; i < n; i++) begin
        k = $urandom_range(0, 9);
        case (k)
          0, 1, 2: prog.push_back(rtype($urandom_range(0, 7), $urandom_range(0, 7),
                                        $urandom_range(0, 7), fnList[$urandom_range(0, 4)]));
          5: prog.push_back(itype(6'h23, 0, $urandom_range(0, 7), 16'('h400 + 4 * $urandom_range(0, 63))));
          6: prog.push_back(itype(6'h2B, 0, $urandom_range(0, 7), 16'('h400 + 4 * $urandom_range(0, 63))));
          7: begin
            off = $urandom_range(0, 3);
            if (off > n - 1 - i) off = n - 1 - i;
            prog.push_back(itype(6'h04, $urandom_range(0, 3), $urandom_range(0, 3), 16'(off)));
          end
          8: begin
            off = $urandom_range(0, 3);
            if (off > n - 1 - i) off = n - 1 - i;
            prog.push_back(jtype(i + 1 + off));
          end
          default: prog.push_back(itype(6'h08, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom)));
        endcase
      end
      for (int d = 0; d < 64; d++) begin
        dIdx.push_back(DATA_IDX + d);
        dVal.push_back($urandom);
      end
      applyStimulus($urandom_range(0, 2));
      runProgram(0);
      checkDump();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
